// File: rtl/mips_boot_pkg.sv
// ---------------------------------------------------------------------------
// mips_boot_pkg : shared types and header-field layout for the boot loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_boot_pkg;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CHK  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } boot_state_e;

  localparam int BASE_MSB       = 31;
  localparam int BASE_LSB       = 16;
  localparam int CNT_LSB        = 0;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

`default_nettype wire

// File: rtl/mips_boot_word_asm.sv
// ---------------------------------------------------------------------------
// mips_boot_word_asm : packs MSB-first bytes into 32-bit words
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_boot_word_asm
  import mips_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]       acc_q, acc_d;

  // The completed word includes the byte being accepted this cycle.
  assign word_o       = {acc_q, byte_i};
  assign word_valid_o = accept_i && (cnt_q == LAST_BYTE);

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (accept_i) begin
      cnt_d = cnt_q + BCNT_W'(1);
      acc_d = {acc_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_boot_loader.sv
// ---------------------------------------------------------------------------
// mips_boot_loader : framed byte-stream image loader for the MIPS32 core
// Optional checksum word: define MIPS_BOOT_CHECKSUM_EN.   Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] cpu_pc,
  output logic              cpu_start,
  output logic              done,
  output logic              error
);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, ptr_q, ptr_d, pc_q, pc_d, addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d, start_q, start_d, halt_q, halt_d, done_q, done_d;
  logic              w_word_valid;
  logic [31:0]       w_word;
`ifdef MIPS_BOOT_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
  logic              err_q, err_d;
`endif

  assign in_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);

  mips_boot_word_asm u_word_asm (
    .clk_i        (clk1),
    .rst_ni       (rst_n),
    .accept_i     (in_valid && in_ready),
    .byte_i       (in_data),
    .word_valid_o (w_word_valid),
    .word_o       (w_word)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    start_d = 1'b0;
    halt_d  = halt_q;
    done_d  = done_q;
`ifdef MIPS_BOOT_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    case (state_q)
      HDR: if (w_word_valid) begin
        base_d = w_word[BASE_LSB +: ADDR_W];
        ptr_d  = w_word[BASE_LSB +: ADDR_W];
        rem_d  = w_word[CNT_LSB +: CNT_W];
`ifdef MIPS_BOOT_CHECKSUM_EN
        csum_d = w_word;
`endif
        if (w_word[CNT_LSB +: CNT_W] != '0) begin
          state_d = DATA;
        end else begin
`ifdef MIPS_BOOT_CHECKSUM_EN
          state_d = CHK;
`else
          // No write to wait for: release the core straight away.
          state_d = DONE;
          pc_d    = w_word[BASE_LSB +: ADDR_W];
          start_d = 1'b1;
          halt_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
      DATA: if (w_word_valid) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = w_word;
        ptr_d   = ptr_q + ADDR_W'(1);
        rem_d   = rem_q - CNT_W'(1);
`ifdef MIPS_BOOT_CHECKSUM_EN
        csum_d  = csum_q ^ w_word;
        if (rem_q == CNT_W'(1)) state_d = CHK;
`else
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
          pc_d    = base_q;
        end
`endif
      end
      CHK: begin
`ifdef MIPS_BOOT_CHECKSUM_EN
        if (w_word_valid) begin
          if (w_word == csum_q) begin
            state_d = DONE;
            pc_d    = base_q;
            start_d = 1'b1;
            halt_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
`endif
      end
      // Arrived with the last write in flight: release one cycle behind it.
      DONE: if (!done_q) begin
        start_d = 1'b1;
        halt_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
      base_q  <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      halt_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      start_q <= start_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
    end
  end

`ifdef MIPS_BOOT_CHECKSUM_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_halt  = halt_q;
  assign cpu_pc    = pc_q;
  assign cpu_start = start_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_mips_boot_loader : randomized self-checking bench for mips_boot_loader
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mips_boot_loader;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;
`ifdef MIPS_BOOT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, mem_we, cpu_halt, cpu_start, done, error;
  logic [ADDR_W-1:0] mem_addr, cpu_pc;
  logic [31:0]       mem_wdata;

  mips_boot_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_halt  (cpu_halt),
    .cpu_pc    (cpu_pc),
    .cpu_start (cpu_start),
    .done      (done),
    .error     (error)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // Observation log, sampled mid-cycle.
  int                hs_q[$];
  int                wr_cyc_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  int                st_cyc_q[$];
  logic [ADDR_W-1:0] st_pc_q[$];
  int                halt0_cyc, done0_cyc;
  logic [31:0]       data_q[$];

  always @(negedge clk1) begin
    if (rst_n) begin
      if (in_valid && in_ready) hs_q.push_back(cyc);
      if (mem_we) begin
        wr_cyc_q.push_back(cyc);
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end
      if (cpu_start) begin
        st_cyc_q.push_back(cyc);
        st_pc_q.push_back(cpu_pc);
      end
      if (!cpu_halt && halt0_cyc < 0) halt0_cyc = cyc;
      if (done && done0_cyc < 0) done0_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    hs_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    st_cyc_q.delete(); st_pc_q.delete();
    halt0_cyc = -1;
    done0_cyc = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"},  in_ready,  1);
    check({tag, " mem_we"},    mem_we,    0);
    check({tag, " mem_addr"},  mem_addr,  0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " cpu_halt"},  cpu_halt,  1);
    check({tag, " cpu_pc"},    cpu_pc,    0);
    check({tag, " cpu_start"}, cpu_start, 0);
    check({tag, " done"},      done,      0);
    check({tag, " error"},     error,     0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;
  endtask

  // Enter and leave one time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
    int gap;
    bit rdy;
    gap = $urandom_range(max_gap, 0);
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk1); #1; end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk1); rdy = in_ready;
      @(posedge clk1); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int nbytes, input int max_gap, output bit ok);
    logic [31:0] tmp;
    ok = 1'b1;
    for (int b = 0; b < nbytes && ok; b++) begin
      tmp = w << (8 * b);
      send_byte(tmp[31:24], max_gap, ok);
    end
  endtask

  // Streams header + data_q (+ checksum) and checks against the image rules.
  task automatic run_case(input string name, input logic [31:0] hdr, input int max_gap,
                          input bit bad, input bit with_reset);
    logic [31:0]       words[$];
    logic [31:0]       x;
    logic [ADDR_W-1:0] base, ea;
    int                n, cf, exp_st, last;
    bit                ok, acc, fin;
    if (with_reset) do_reset();
    clear_mon();
    n    = int'(hdr[CNT_W-1:0]);
    base = hdr[16 +: ADDR_W];
    words.push_back(hdr);
    x = hdr;
    foreach (data_q[i]) begin
      words.push_back(data_q[i]);
      x = x ^ data_q[i];
    end
    if (CSUM) words.push_back(bad ? (x ^ 32'h0000_0001) : x);
    ok  = !(CSUM && bad);
    acc = 1'b1;
    foreach (words[w]) begin
      if (acc) send_word(words[w], 4, max_gap, acc);
    end
    if (!acc) check({name, " byte accept timeout"}, 0, 1);

    fin = 1'b0;
    for (int t = 0; t < 30 && !fin; t++) begin
      @(negedge clk1);
      fin = done || error;
    end
    check({name, " finished"}, fin, 1);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    repeat (4) @(posedge clk1);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk1);
    #1;

    check({name, " handshakes"}, hs_q.size(), 4 * words.size());
    check({name, " write count"}, wr_cyc_q.size(), n);
    for (int j = 0; j < n && j < wr_cyc_q.size(); j++) begin
      ea = base + ADDR_W'(j);
      check($sformatf("%s wr%0d addr", name, j), wr_addr_q[j], ea);
      check($sformatf("%s wr%0d data", name, j), wr_data_q[j], data_q[j]);
      if (hs_q.size() > 4 * (j + 1) + 3)
        check($sformatf("%s wr%0d cycle", name, j), wr_cyc_q[j], hs_q[4 * (j + 1) + 3] + 1);
    end
    check({name, " start pulses"}, st_cyc_q.size(), ok ? 1 : 0);
    last = words.size() - 1;
    if (ok && st_cyc_q.size() > 0 && hs_q.size() >= 4 * words.size()) begin
      cf     = hs_q[4 * last + 3];
      exp_st = cf + ((n > 0 && !CSUM) ? 2 : 1);
      check({name, " start cycle"}, st_cyc_q[0], exp_st);
      check({name, " start pc"},    st_pc_q[0],  base);
      check({name, " halt fall"},   halt0_cyc,   exp_st);
      check({name, " done rise"},   done0_cyc,   exp_st);
    end
    if (!ok) check({name, " halt never fell"}, halt0_cyc, -1);
    check({name, " done"},     done,     ok);
    check({name, " error"},    error,    !ok);
    check({name, " cpu_halt"}, cpu_halt, !ok);
    check({name, " in_ready"}, in_ready, 0);
    if (ok) check({name, " cpu_pc"}, cpu_pc, base);
  endtask

  initial begin
    logic [31:0] hdr;
    bit          acc;
    int          n;

    do_reset();
    check_reset_vals("reset");

    data_q = '{32'h28010078, 32'h0c631800, 32'h20220000};
    run_case("prog3", 32'h00000003, 0, 0, 1);

    data_q = '{32'h00000055};
    run_case("base120", 32'h00780001, 1, 0, 1);

    data_q = '{32'hAAAAAAAA, 32'hBBBBBBBB};
    run_case("wrap", 32'h03FF0002, 2, 0, 1);

    data_q.delete();
    run_case("count0", 32'h02A00000, 0, 0, 1);

    for (int r = 0; r < 6; r++) begin
      n = (r == 0) ? 0 : $urandom_range(5, 1);
      hdr[31:26] = 6'($urandom);
      hdr[25:16] = (r == 1) ? 10'h3FE : 10'($urandom);
      hdr[15:0]  = 16'(n);
      data_q.delete();
      for (int j = 0; j < n; j++) data_q.push_back($urandom);
      run_case($sformatf("rand%0d", r), hdr, 3, r[0], 1);
    end

    // Async reset partway into the second data word.
    do_reset();
    clear_mon();
    send_word(32'h00000003, 4, 0, acc);
    if (acc) send_word(32'h11223344, 4, 0, acc);
    if (acc) send_word(32'h55667788, 2, 0, acc);
    check("midreset accept", acc, 1);
    @(posedge clk1); #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    check("midreset writes before reset", wr_cyc_q.size(), 1);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;
    data_q = '{32'hCAFEBABE, 32'h12345678};
    run_case("after_reset", 32'h01000002, 1, 0, 0);

`ifdef MIPS_BOOT_CHECKSUM_EN
    data_q = '{32'h11111111};
    run_case("csum_ok", 32'h00000001, 0, 0, 1);
    run_case("csum_bad", 32'h00000001, 0, 1, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Byte-serial program loader that sits directly upstream of the pipelined MIPS32 core.
- Receives a framed image over a valid/ready byte stream, assembles big-endian 32-bit words, and writes them into the core's unified instruction/data memory through a write port.
- Holds the core halted while loading, then releases it with the start PC.
- Replaces bench-side direct memory/PC pokes in system-level builds.

Parameters:
- ADDR_W, 10, word-address width of the core memory (1024 words).
- CNT_W, 16, width of the header word-count field (values up to 2^CNT_W-1).

Ports:
- clk1  in  1  system clock; the core's phase-1 clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte, MSB-first within each word.
- in_ready  out  1  loader accepts a byte this cycle; transfer when in_valid & in_ready.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  word address for write.
- mem_wdata  out  32  write data.
- cpu_halt  out  1  drives the core's HALTED; 1 holds the core.
- cpu_pc  out  ADDR_W  start PC presented to the core; valid when cpu_start=1.
- cpu_start  out  1  one-cycle pulse: core loads PC=cpu_pc, clears HALTED and TAKEN_BRANCH.
- done  out  1  sticky; image loaded and core released.
- error  out  1  sticky; framing/checksum failure.

Behaviour:
- Reset (async, any state): state=HDR; byte counter=0; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; cpu_halt=1; cpu_pc=0; cpu_start=0; done=0; error=0.
- Reset mid-load discards the partial image. Memory already written is not scrubbed.
- Word assembly:
  - A 2-bit byte counter; each accepted byte shifts into {acc[23:0], in_data}.
  - The 4th accepted byte completes a word. The completed word equals the shifted value including that byte.
- Header word (state HDR):
  - Bits [31:16] = load base address; only the low ADDR_W bits are used.
  - Bits [CNT_W-1:0] = word count N.
  - Base and N are latched on completion; the write pointer is set to base.
- Transitions:
  - HDR -> DATA if N>0.
  - HDR -> CHK (CHECKSUM_EN) or DONE if N=0.
  - DATA -> CHK/DONE after the Nth word.
  - DONE and ERR are terminal until reset.
- Data write:
  - On completion of each DATA word, the next cycle has mem_we=1, mem_addr=ptr, mem_wdata=word. Latency: 1 cycle after the 4th byte handshake.
  - ptr increments by 1 modulo 2^ADDR_W; wrap past the top address silently continues at 0.
  - Back-to-back bytes are supported. The writes are naturally spaced at least 4 cycles apart, so there are no write collisions.
- Entering DONE:
  - In the same cycle as the final mem_we, register cpu_pc=base.
  - The following cycle: cpu_start=1 for exactly one cycle, cpu_halt falls to 0, done=1.
  - The final memory write is therefore committed before the core is released.
- DONE/ERR: in_ready=0; bytes offered are ignored (not consumed). cpu_halt stays at its value (0 in DONE, 1 in ERR).
- in_valid low mid-word: the partial word is held indefinitely; there is no timeout.

Optional Feature:
- Macro: MIPS_BOOT_CHECKSUM_EN.
- Defined:
  - After the data words, state CHK expects one extra word equal to the XOR of the header word and all data words.
  - On a match -> DONE as above.
  - On a mismatch -> ERR: error=1, cpu_halt stays 1, cpu_start never pulses.
  - Data writes still occur during DATA.
- Undefined: no CHK state or checksum register; error is tied 0; DATA goes directly to DONE.

Decomposition:
- Shared package mips_boot_pkg:
  - State enum {HDR, DATA, CHK, DONE, ERR}.
  - Header field positions (BASE_MSB=31, BASE_LSB=16, CNT_LSB=0).
  - BYTES_PER_WORD=4.
- Sub-module mips_boot_word_asm:
  - Byte counter, shift accumulator, word_valid pulse.
  - Reused later by the UART debug port.

Test Plan:
- Stream header 32'h00000003, then words 28010078, 0c631800, 20220000 with in_valid held 1 -> three mem_we pulses at addresses 0,1,2 with exactly those data; each write 1 cycle after its 4th byte. Then cpu_start pulse with cpu_pc=0, cpu_halt 1->0, done=1; in_ready=0 afterwards.
- Header 32'h00780001, data 32'h00000055 -> single write Mem[120]=85; cpu_pc=120.
- Header 32'h03FF0002 (ADDR_W=10), data A, B -> writes at 1023 then 0 (wrap).
- Header count 0 -> no mem_we; cpu_start pulse 1 cycle after header completion (checksum off).
- Assert rst_n low after the 2nd byte of the 2nd data word -> all outputs return to reset values immediately. A fresh header is accepted afterwards, and the stale partial word is never written.
- With MIPS_BOOT_CHECKSUM_EN: header 32'h00000001, data 32'h11111111, checksum 32'h11111110 -> done=1. With checksum 32'h0 instead -> error=1, cpu_halt stays 1, no cpu_start.
